// File: rtl/fb_write_arbiter_if.sv
// Frame-buffer write bus shared by two pixel sources and one arbiter.
// slave: arbiter side; master: sources / frame-buffer side.
interface fb_write_arbiter_if #(
    parameter int LOG_N_ROWS = 6,
    parameter int LOG_N_COLS = 6
);
    logic                  req0;
    logic                  req1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  wren0;
    logic                  wren1;
    logic [23:0]           data0;
    logic [23:0]           data1;
    logic [LOG_N_COLS-1:0] col0;
    logic [LOG_N_COLS-1:0] col1;
    logic [LOG_N_ROWS-1:0] row0;
    logic [LOG_N_ROWS-1:0] row1;
    logic                  store0;
    logic                  store1;
    logic                  rswap0;
    logic                  rswap1;
    logic                  fswap0;
    logic                  fswap1;
    logic                  fbw_wren;
    logic [23:0]           fbw_data;
    logic [LOG_N_COLS-1:0] fbw_col_addr;
    logic [LOG_N_ROWS-1:0] fbw_row_addr;
    logic                  fbw_row_store;
    logic                  fbw_row_swap;
    logic                  fbw_frame_swap;
    logic                  fbw_row_rdy;
    logic                  fbw_frame_rdy;
    logic                  busy;
    logic                  swap_drop;

    modport slave (
        input  req0, req1, wren0, wren1, data0, data1,
        input  col0, col1, row0, row1, store0, store1,
        input  rswap0, rswap1, fswap0, fswap1,
        input  fbw_row_rdy, fbw_frame_rdy,
        output gnt0, gnt1, fbw_wren, fbw_data,
        output fbw_col_addr, fbw_row_addr, fbw_row_store,
        output fbw_row_swap, fbw_frame_swap, busy, swap_drop
    );

    modport master (
        output req0, req1, wren0, wren1, data0, data1,
        output col0, col1, row0, row1, store0, store1,
        output rswap0, rswap1, fswap0, fswap1,
        output fbw_row_rdy, fbw_frame_rdy,
        input  gnt0, gnt1, fbw_wren, fbw_data,
        input  fbw_col_addr, fbw_row_addr, fbw_row_store,
        input  fbw_row_swap, fbw_frame_swap, busy, swap_drop
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter granting one of two sources the frame-buffer write port.
// Ports: clk, rst_n (async active-low), bus (fb_write_arbiter_if.slave).
module fb_write_arbiter #(
    parameter int LOG_N_ROWS = 6,
    parameter int LOG_N_COLS = 6,
    parameter int DRAIN_MIN  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fb_write_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_MIN - 1);

    state_t     state_q, state_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic       busy_q;
    logic       swap_drop_q, swap_drop_d;
    logic       rst_done_q;

    logic                  o_req;
    logic                  o_wren;
    logic [23:0]           o_data;
    logic [LOG_N_COLS-1:0] o_col;
    logic [LOG_N_ROWS-1:0] o_row;
    logic                  o_store;
    logic                  o_rswap;
    logic                  o_fswap;
    logic                  fwd;
    logic                  pick1;

    // Owner select: in OWN exactly one gnt is set, so gnt1 names the owner.
    assign o_req   = gnt1_q ? bus.req1   : bus.req0;
    assign o_wren  = gnt1_q ? bus.wren1  : bus.wren0;
    assign o_data  = gnt1_q ? bus.data1  : bus.data0;
    assign o_col   = gnt1_q ? bus.col1   : bus.col0;
    assign o_row   = gnt1_q ? bus.row1   : bus.row0;
    assign o_store = gnt1_q ? bus.store1 : bus.store0;
    assign o_rswap = gnt1_q ? bus.rswap1 : bus.rswap0;
    assign o_fswap = gnt1_q ? bus.fswap1 : bus.fswap0;

    // A store wins over a dropped request, so it still forwards.
    assign fwd = (state_q == OWN) && (o_req || o_store);

    // Source 1 wins alone, or in a tie when source 0 was served last.
    assign pick1 = bus.req1 && (!bus.req0 || !last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= 4'd0;
            busy_q      <= 1'b0;
            swap_drop_q <= 1'b0;
            rst_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            busy_q      <= (state_d != IDLE);
            swap_drop_q <= swap_drop_d;
            // Blocks a grant on the first edge after reset release.
            rst_done_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt0_d      = gnt0_q;
        gnt1_d      = gnt1_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        swap_drop_d = fwd && o_fswap && !bus.fbw_frame_rdy;
        unique case (state_q)
            IDLE: begin
                if (rst_done_q && bus.fbw_row_rdy &&
                    (bus.req0 || bus.req1)) begin
                    state_d = OWN;
                    gnt1_d  = pick1;
                    gnt0_d  = !pick1;
                end
            end
            OWN: begin
                if (o_store) begin
                    state_d = DRAIN;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    last_d  = gnt1_q;
                    cnt_d   = 4'd0;
                end else if (!o_req) begin
                    state_d = IDLE;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    last_d  = gnt1_q;
                end
            end
            DRAIN: begin
                if (cnt_q >= DRAIN_LAST && bus.fbw_row_rdy) begin
                    state_d = IDLE;
                end else if (cnt_q != 4'hF) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        bus.fbw_wren       = 1'b0;
        bus.fbw_data       = '0;
        bus.fbw_col_addr   = '0;
        bus.fbw_row_addr   = '0;
        bus.fbw_row_store  = 1'b0;
        bus.fbw_row_swap   = 1'b0;
        bus.fbw_frame_swap = 1'b0;
        if (fwd) begin
            bus.fbw_wren       = o_wren;
            bus.fbw_data       = o_data;
            bus.fbw_col_addr   = o_col;
            bus.fbw_row_addr   = o_row;
            bus.fbw_row_store  = o_store;
            bus.fbw_row_swap   = o_rswap;
            bus.fbw_frame_swap = o_fswap && bus.fbw_frame_rdy;
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.busy      = busy_q;
    assign bus.swap_drop = swap_drop_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed self-checking bench for fb_write_arbiter.
// Drives inputs 2ns after each rising edge and samples before the next.
module tb_fb_write_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   both_seen;
    int   hold_bad;

    fb_write_arbiter_if #(.LOG_N_ROWS(6), .LOG_N_COLS(6)) bus ();

    fb_write_arbiter #(
        .LOG_N_ROWS(6),
        .LOG_N_COLS(6),
        .DRAIN_MIN (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus.gnt0 && bus.gnt1) both_seen = 1;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_gnt(input string tag);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.gnt0 || bus.gnt1) break;
        end
        check(tag, 32'(bus.gnt0 | bus.gnt1), 32'd1);
    endtask

    task automatic clear_inputs();
        bus.req0 = 0; bus.req1 = 0;
        bus.wren0 = 0; bus.wren1 = 0;
        bus.data0 = '0; bus.data1 = '0;
        bus.col0 = '0; bus.col1 = '0;
        bus.row0 = '0; bus.row1 = '0;
        bus.store0 = 0; bus.store1 = 0;
        bus.rswap0 = 0; bus.rswap1 = 0;
        bus.fswap0 = 0; bus.fswap1 = 0;
        bus.fbw_row_rdy = 0;
        bus.fbw_frame_rdy = 0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        both_seen = 0;
        hold_bad = 0;
        rst_n = 0;
        clear_inputs();

        // Reset state
        tick();
        check("rst_gnt0", 32'(bus.gnt0), 32'd0);
        check("rst_gnt1", 32'(bus.gnt1), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_drop", 32'(bus.swap_drop), 32'd0);

        // No grant on the first edge after release
        rst_n = 1;
        bus.req0 = 1; bus.req1 = 1;
        bus.fbw_row_rdy = 1;
        tick();
        check("first_edge_gnt",
              32'({bus.gnt1, bus.gnt0}), 32'd0);

        // Three rows, both requesting: 0,1,0
        for (int r = 0; r < 3; r++) begin
            wait_gnt("rr_wait");
            check("rr_owner", 32'({bus.gnt1, bus.gnt0}),
                  (r % 2 == 0) ? 32'd1 : 32'd2);
            if (bus.gnt1) bus.store1 = 1;
            else          bus.store0 = 1;
            #1;
            check("rr_store_fwd", 32'(bus.fbw_row_store), 32'd1);
            tick();
            bus.store0 = 0; bus.store1 = 0;
        end
        check("rr_both_gnt", 32'(both_seen), 32'd0);
        bus.req0 = 0; bus.req1 = 0;
        repeat (4) tick();
        check("rr_idle_busy", 32'(bus.busy), 32'd0);

        // Single requester wins despite history; pixel row
        bus.req0 = 1;
        wait_gnt("pix_wait");
        check("pix_gnt0", 32'({bus.gnt1, bus.gnt0}), 32'd1);
        check("pix_busy", 32'(bus.busy), 32'd1);
        for (int c = 0; c < 64; c++) begin
            bus.wren0 = 1;
            bus.data0 = {8'(c), 8'hA5, 8'(63 - c)};
            bus.col0  = 6'(c);
            bus.row0  = 6'd17;
            #1;
            check("pix_wren", 32'(bus.fbw_wren), 32'd1);
            check("pix_data", 32'(bus.fbw_data),
                  32'({8'(c), 8'hA5, 8'(63 - c)}));
            check("pix_col", 32'(bus.fbw_col_addr), 32'(c));
            tick();
        end
        check("pix_row", 32'(bus.fbw_row_addr), 32'd17);

        // Store, then hold row_rdy low in DRAIN
        bus.wren0 = 0; bus.store0 = 1; bus.req0 = 0;
        bus.req1 = 1;
        #1;
        check("st_fwd", 32'(bus.fbw_row_store), 32'd1);
        bus.fbw_row_rdy = 0;
        tick();
        bus.store0 = 0;
        check("st_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
        check("st_busy", 32'(bus.busy), 32'd1);
        check("st_drain_zero", 32'(bus.fbw_row_store), 32'd0);
        check("st_drain_data", 32'(bus.fbw_data), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!bus.busy || bus.gnt1 || bus.gnt0) hold_bad = 1;
        end
        check("drain_hold", 32'(hold_bad), 32'd0);
        bus.fbw_row_rdy = 1;
        tick();
        check("drain_exit_busy", 32'(bus.busy), 32'd0);
        check("drain_exit_gnt", 32'(bus.gnt1), 32'd0);
        tick();
        check("drain_then_gnt1", 32'({bus.gnt1, bus.gnt0}), 32'd2);

        // Source 1 owns; source 0 noise ignored
        bus.wren0 = 1; bus.data0 = 24'hFFFFFF;
        bus.col0 = 6'd63; bus.row0 = 6'd63;
        bus.wren1 = 1; bus.data1 = 24'h123456;
        bus.col1 = 6'd7; bus.row1 = 6'd9;
        #1;
        check("own1_data", 32'(bus.fbw_data), 32'h123456);
        check("own1_col", 32'(bus.fbw_col_addr), 32'd7);
        check("own1_row", 32'(bus.fbw_row_addr), 32'd9);
        check("own1_wren", 32'(bus.fbw_wren), 32'd1);
        bus.wren1 = 0;
        #1;
        check("own1_wren_off", 32'(bus.fbw_wren), 32'd0);
        bus.store0 = 1; bus.fswap0 = 1; bus.rswap0 = 1;
        bus.fbw_frame_rdy = 0;
        #1;
        check("nonown_store", 32'(bus.fbw_row_store), 32'd0);
        check("nonown_rswap", 32'(bus.fbw_row_swap), 32'd0);
        tick();
        bus.store0 = 0; bus.fswap0 = 0; bus.rswap0 = 0;
        check("nonown_drop", 32'(bus.swap_drop), 32'd0);
        check("nonown_state", 32'(bus.gnt1), 32'd1);

        // Owner frame swap, not ready then ready
        bus.fswap1 = 1; bus.fbw_frame_rdy = 0;
        #1;
        check("fs0_swap", 32'(bus.fbw_frame_swap), 32'd0);
        check("fs0_drop_now", 32'(bus.swap_drop), 32'd0);
        tick();
        bus.fswap1 = 0;
        check("fs0_drop", 32'(bus.swap_drop), 32'd1);
        tick();
        check("fs0_drop_end", 32'(bus.swap_drop), 32'd0);
        bus.fswap1 = 1; bus.fbw_frame_rdy = 1;
        bus.rswap1 = 1;
        #1;
        check("fs1_swap", 32'(bus.fbw_frame_swap), 32'd1);
        check("own1_rswap", 32'(bus.fbw_row_swap), 32'd1);
        tick();
        bus.fswap1 = 0; bus.rswap1 = 0;
        check("fs1_drop", 32'(bus.swap_drop), 32'd0);
        check("fs1_state", 32'(bus.gnt1), 32'd1);

        // Reset mid-row with swap_drop pending
        bus.fswap1 = 1; bus.fbw_frame_rdy = 0;
        tick();
        bus.fswap1 = 0;
        bus.wren1 = 1;
        rst_n = 0;
        #1;
        check("mrst_gnt1", 32'(bus.gnt1), 32'd0);
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_wren", 32'(bus.fbw_wren), 32'd0);
        check("mrst_drop", 32'(bus.swap_drop), 32'd0);
        tick();
        rst_n = 1;
        bus.wren1 = 0;
        bus.req0 = 1; bus.req1 = 1;
        bus.fbw_row_rdy = 1;
        wait_gnt("mrst_wait");
        check("mrst_first", 32'({bus.gnt1, bus.gnt0}), 32'd1);

        // Owner drops req: nothing forwarded, back to IDLE
        bus.req0 = 0; bus.wren0 = 1;
        #1;
        check("drop_wren", 32'(bus.fbw_wren), 32'd0);
        tick();
        check("drop_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
        check("drop_busy", 32'(bus.busy), 32'd0);
        bus.req0 = 1;
        tick();
        check("drop_rr", 32'({bus.gnt1, bus.gnt0}), 32'd2);

        // Store with coincident req drop still forwards
        bus.req1 = 0; bus.store1 = 1; bus.req0 = 0;
        #1;
        check("coinc_fwd", 32'(bus.fbw_row_store), 32'd1);
        tick();
        bus.store1 = 0;
        check("coinc_busy", 32'(bus.busy), 32'd1);
        check("coinc_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);

        clear_inputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 Parameter LOG_N_ROWS, default 6, row address width.
REQ-002 Parameter LOG_N_COLS, default 6, column address width.
REQ-003 Parameter DRAIN_MIN, default 2, minimum cycles in DRAIN before fbw_row_rdy is sampled; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 req0 / req1  input  1  source 0 / source 1 requests frame-buffer write ownership.
REQ-007 gnt0 / gnt1  output  1  source 0 / source 1 owns the write port; registered.
REQ-008 wren0/1, data0/1 [23:0], col0/1 [LOG_N_COLS-1:0], row0/1 [LOG_N_ROWS-1:0]  input  per-source pixel write, column, row.
REQ-009 store0/1, rswap0/1, fswap0/1  input  1  per-source row-store, row-swap and frame-swap pulses.
REQ-010 fbw_wren, fbw_data [23:0], fbw_col_addr, fbw_row_addr, fbw_row_store, fbw_row_swap, fbw_frame_swap  output  muxed frame-buffer write port.
REQ-011 fbw_row_rdy, fbw_frame_rdy  input  1  frame buffer ready for a new row / a frame swap.
REQ-012 busy  output  1  state is not IDLE.
REQ-013 swap_drop  output  1  one-cycle pulse: owner fswap discarded because fbw_frame_rdy was 0.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, OWN, DRAIN.
REQ-015 IDLE: if fbw_row_rdy=1 and at least one req is high, the block SHALL move to OWN and set exactly one gnt on the next edge.
REQ-016 Selection SHALL be round-robin: with both requests high, the source not served last wins; after reset, source 0 has priority.
REQ-017 With one request high, that source SHALL be granted regardless of round-robin history.
REQ-018 In OWN, fbw_wren, fbw_data, fbw_col_addr, fbw_row_addr, fbw_row_store and fbw_row_swap SHALL combinationally follow the owner's inputs in the same cycle (zero latency).
REQ-019 Non-owner inputs SHALL be ignored entirely.
REQ-020 In IDLE and DRAIN, all fbw_* strobes SHALL be 0 and address/data outputs SHALL be 0.
REQ-021 Owner store=1 in OWN: forwarded that cycle; next edge: state DRAIN, gnt cleared, owner recorded as last-served.
REQ-022 Owner req dropping to 0 in OWN without store: next edge: IDLE, gnt cleared, owner recorded as last-served; nothing forwarded that cycle.
REQ-023 If store and req-deassert coincide, store SHALL take precedence (forwarded, go to DRAIN).
REQ-024 DRAIN SHALL hold for at least DRAIN_MIN cycles (4-bit counter), then exit to IDLE on the first cycle with fbw_row_rdy=1.
REQ-025 Owner fswap in OWN with fbw_frame_rdy=1: fbw_frame_swap=1 the same cycle; state unchanged.
REQ-026 Owner fswap in OWN with fbw_frame_rdy=0: fbw_frame_swap=0 and swap_drop=1 for one cycle (registered, one-cycle latency).
REQ-027 Pulses from a source not in OWN (including fswap) SHALL be discarded and SHALL NOT set swap_drop.
REQ-028 gnt0 and gnt1 SHALL never be high simultaneously; gnt SHALL be high only in OWN.
REQ-029 busy SHALL be a registered decode of the state: 1 in OWN and DRAIN.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately force IDLE, gnt0=gnt1=0, busy=0, swap_drop=0, drain counter 0 and last-served=source 1 (so source 0 wins first), even mid-row.
REQ-031 After rst_n deasserts, the first grant SHALL occur no earlier than the second rising edge.

Verification
REQ-032 req0=1, fbw_row_rdy=1 from idle -> gnt0=1 next edge; owner pixels col 0..63 appear on fbw_* the same cycles; store0 -> DRAIN, gnt0=0 next edge.
REQ-033 req0=req1=1 held for three rows -> grants alternate 0,1,0; no cycle with both gnt high.
REQ-034 Source 1 owns and asserts wren1 while wren0=1 with data0=24'hFFFFFF -> fbw_data equals data1 only; fbw_wren follows wren1.
REQ-035 After store, fbw_row_rdy held 0 for 10 cycles, DRAIN_MIN=2 -> busy stays 1, no grant until 1 edge after rdy=1.
REQ-036 Owner fswap with fbw_frame_rdy=0 -> fbw_frame_swap=0 and swap_drop=1 one cycle later; repeat with rdy=1 -> fbw_frame_swap=1 same cycle, swap_drop=0.
REQ-037 rst_n=0 mid-row while gnt1=1 -> gnt1=0, busy=0, fbw_wren=0 immediately; after release, req0=req1=1 -> source 0 granted first.
